// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one result bit per clock.
// One shift-and-correct unit shared through a start/busy/done handshake.
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out,
    output logic [1:0]            dbg_state
);

    localparam int S_W  = 4 * DIGITS;
    localparam int CW   = $clog2(BIN_W);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    // REJECT spends one busy cycle on a request with a non-decimal digit
    // so that its done lands two edges after acceptance.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REJECT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [S_W-1:0]    s_reg;
    logic [BIN_W-1:0]  a_reg;
    logic [CW-1:0]     cnt;
    logic [S_W-1:0]    s_shift;
    logic [S_W-1:0]    s_fix;
    logic [BIN_W-1:0]  a_shift;
    logic              bad_digit;

    always_comb begin
        s_shift = {1'b0, s_reg[S_W-1:1]};
        a_shift = {s_reg[0], a_reg[BIN_W-1:1]};
        s_fix   = s_shift;
        for (int d = 0; d < DIGITS; d++) begin
            if (s_shift[4*d +: 4] >= 4'd8)
                s_fix[4*d +: 4] = s_shift[4*d +: 4] - 4'd3;
        end
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] > 4'd9)
                bad_digit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = bad_digit ? REJECT : SHIFT;
            end
            SHIFT: begin
                if (cnt == LAST)
                    state_d = DONE;
            end
            REJECT:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_reg   <= '0;
            a_reg   <= '0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        s_reg <= bcd_in;
                        a_reg <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    s_reg <= s_fix;
                    a_reg <= a_shift;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bin_out <= a_shift;
                        err     <= 1'b0;
                    end
                end
                REJECT: begin
                    s_reg   <= '0;
                    bin_out <= '0;
                    err     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q == SHIFT) || (state_q == REJECT);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: drivers push expected {err, bin_out} and done edge,
// an independent monitor pops and compares on every done pulse.
module tb_bcd_to_bin;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [13:0] bin_out;
    logic [1:0]  dbg_state;

    logic [14:0] exp_q[$];
    int          edge_q[$];
    int          edge_cnt = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bin_out   (bin_out),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d",
                     name, act, act, req, req, edge_cnt);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            check("busy_with_done", {31'd0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [14:0] e;
                int          ee;
                e  = exp_q.pop_front();
                ee = edge_q.pop_front();
                check("bin_out", {18'd0, bin_out}, {18'd0, e[13:0]});
                check("err", {31'd0, err}, {31'd0, e[14]});
                check("done_latency", edge_cnt, ee);
                if (!e[14])
                    check("s_reg_empty", {16'd0, dut.s_reg}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy && !done) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [15:0] bcd, input logic [13:0] eb, input logic ee,
                         input bit push);
        wait_idle();
        start  = 1'b1;
        bcd_in = bcd;
        if (push) begin
            exp_q.push_back({ee, eb});
            edge_q.push_back(edge_cnt + (ee ? 2 : 15));
        end
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'($urandom);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_bin_out", {18'd0, bin_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1/T2: directed valid conversions
        issue(16'h9999, 14'd9999, 1'b0, 1);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        issue(16'h0000, 14'd0, 1'b0, 1);
        issue(16'h2047, 14'd2047, 1'b0, 1);

        // T3: invalid digit, then err must hold until the next done
        issue(16'h12A4, 14'd0, 1'b1, 1);
        issue(16'h0001, 14'd1, 1'b0, 1);
        check("err_held", {31'd0, err}, 32'd1);

        // T4: start pulses while busy and in the DONE cycle are ignored
        issue(16'h0500, 14'd500, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            repeat (2) @(negedge clk);
            start  = 1'b1;
            bcd_in = 16'h0777;
            @(negedge clk);
            start  = 1'b0;
        end
        wait_done();
        start  = 1'b1;
        bcd_in = 16'h0777;
        @(negedge clk);
        start  = 1'b0;
        repeat (40) @(negedge clk);

        // T5: reset on the 7th SHIFT edge aborts the conversion
        issue(16'h1234, 14'd0, 1'b0, 0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        check("abort_bin_out", {18'd0, bin_out}, 32'd0);
        check("abort_state", {30'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(16'h1234, 14'd1234, 1'b0, 1);

        // T6: start held high, one conversion every 16 edges
        wait_idle();
        start  = 1'b1;
        bcd_in = 16'h9999;
        exp_q.push_back({1'b0, 14'd9999});
        edge_q.push_back(edge_cnt + 15);
        for (int i = 0; i < 300; i++) begin
            int v;
            v = (i * 331 + 7) % 10000;
            wait_done();
            bcd_in = to_bcd(v);
            exp_q.push_back({1'b0, 14'(v)});
            edge_q.push_back(edge_cnt + 16);
        end
        wait_done();
        start = 1'b0;

        repeat (40) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
